echo_delay_proc: RTL and testbench

- Parametrised audio echo processor between the ADC front end and the DAC driver.
- Subtracts a scaled, delayed sample from the offset-corrected input.
- Modes: passthrough, single echo (feed-forward), multiple echoes (feedback).
- Internal circular delay buffer with run-time delay select, post-reset buffer clear, internal data_valid edge detection, and overrun flagging.

---
 rtl/echo_delay_proc.sv | 100 ++++++++++
 tb/tb_echo_delay_proc.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/echo_delay_proc.sv
// echo_delay_proc: audio echo processor, y = x - (delayed >>> GAIN_SHIFT), circular delay buffer
// Optional macro: ECHO_SAT_EN clamps y to the signed DATA_W range instead of wrapping.
// Ports:
//    sysclk     - system clock, rising edge
//    rst_n      - synchronous active-low reset, restarts the buffer clear
//    data_valid - ADC sample-ready level, each rising edge is one new sample
//    data_in    - offset-binary ADC sample
//    delay_sel  - echo delay select, delay = delay_sel << DELAY_SHIFT samples (0 = full buffer)
//    mode       - 00/11 pass, 01 single echo (FIR), 10 multiple echo (IIR)
//    data_out   - registered offset-binary DAC sample
//    out_valid  - one-cycle pulse when data_out updates
//    busy       - high while clearing the buffer or processing a sample
//    overrun    - sticky, a sample edge arrived while a sample was in flight
module echo_delay_proc #(
   parameter int DATA_W = 10,
   parameter int ADDR_W = 13,
   parameter int DELAY_SHIFT = 4,
   parameter int GAIN_SHIFT = 1,
   parameter logic [DATA_W-1:0] ADC_OFFSET = 10'h181,
   parameter logic [DATA_W-1:0] DAC_OFFSET = 10'h200
) (
   input  logic                      sysclk,
   input  logic                      rst_n,
   input  logic                      data_valid,
   input  logic [DATA_W-1:0]         data_in,
   input  logic [ADDR_W-DELAY_SHIFT-1:0] delay_sel,
   input  logic [1:0]                mode,
   output logic [DATA_W-1:0]         data_out,
   output logic                      out_valid,
   output logic                      busy,
   output logic                      overrun
);
   typedef enum logic [1:0] {CLEAR, IDLE, RD, CALC} state_t;
   state_t state, nxt;
   logic [DATA_W-1:0] dly_mem [2**ADDR_W];
   logic [ADDR_W-1:0] wr_ptr, clr_ptr, rd_addr;
   logic [DATA_W-1:0] x, rd_data, y, y_echo;
   logic signed [DATA_W-1:0] echo;
   logic [1:0] mode_q;
   logic dv_q, strobe;
`ifdef ECHO_SAT_EN
   logic [DATA_W:0] diff;
`endif
   assign strobe = data_valid & ~dv_q;
   always_comb begin
      nxt = state;
      unique case (state)
         CLEAR: nxt = (clr_ptr == '1) ? IDLE : CLEAR;
         IDLE:  nxt = strobe ? RD : IDLE;
         RD:    nxt = CALC;
         default: nxt = IDLE;
      endcase
      busy = (state != IDLE);
   end
   always_comb begin
      echo = $signed(rd_data) >>> GAIN_SHIFT;
`ifdef ECHO_SAT_EN
      // one extra bit exposes overflow: top two bits differ means out of range
      diff = {x[DATA_W-1], x} - {echo[DATA_W-1], echo};
      y_echo = (diff[DATA_W] != diff[DATA_W-1])
             ? (diff[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}})
             : diff[DATA_W-1:0];
`else
      y_echo = x - echo;
`endif
      y = (mode_q == 2'b01 || mode_q == 2'b10) ? y_echo : x;
   end
   always_ff @(posedge sysclk) begin
      if (!rst_n) begin
         state <= CLEAR;
         wr_ptr <= '0;
         clr_ptr <= '0;
         dv_q <= 1'b0;
         data_out <= DAC_OFFSET;
         out_valid <= 1'b0;
         overrun <= 1'b0;
      end else begin
         state <= nxt;
         dv_q <= data_valid;
         out_valid <= (state == CALC);
         if (state == CLEAR) clr_ptr <= clr_ptr + 1'b1;
         if (state == CALC) begin
            data_out <= y + DAC_OFFSET;
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (strobe && (state == RD || state == CALC)) overrun <= 1'b1;
      end
   end
   // datapath and buffer carry no reset; the buffer is zeroed by the CLEAR sweep
   always_ff @(posedge sysclk) begin
      if (state == IDLE && strobe) begin
         x <= data_in - ADC_OFFSET;
         rd_addr <= wr_ptr - (ADDR_W'(delay_sel) << DELAY_SHIFT);
         mode_q <= mode;
      end
      if (state == RD) rd_data <= dly_mem[rd_addr];
      if (rst_n && (state == CLEAR || state == CALC))
         dly_mem[state == CLEAR ? clr_ptr : wr_ptr] <= (state == CLEAR) ? '0 : (mode_q == 2'b10 ? y : x);
   end
endmodule

// File: tb/tb_echo_delay_proc.sv
// tb_echo_delay_proc: scoreboard bench for echo_delay_proc (ADDR_W=4, DELAY_SHIFT=0, GAIN_SHIFT=1)
module tb_echo_delay_proc;
   logic sysclk = 1'b0;
   logic rst_n = 1'b0;
   logic data_valid = 1'b0;
   logic [9:0] data_in = '0;
   logic [3:0] delay_sel = '0;
   logic [1:0] mode = '0;
   logic [9:0] data_out;
   logic out_valid, busy, overrun;
   int tests = 0;
   int fails = 0;
   int cyc = 0;
   typedef struct {
      logic [9:0] d;
      int c;
   } exp_t;
   exp_t q[$];
   exp_t e;

   echo_delay_proc #(.DATA_W(10), .ADDR_W(4), .DELAY_SHIFT(0), .GAIN_SHIFT(1)) dut (
      .sysclk(sysclk), .rst_n(rst_n), .data_valid(data_valid), .data_in(data_in),
      .delay_sel(delay_sel), .mode(mode), .data_out(data_out), .out_valid(out_valid),
      .busy(busy), .overrun(overrun)
   );

   always #5 sysclk = ~sysclk;
   always @(posedge sysclk) cyc <= cyc + 1;

   always @(negedge sysclk) begin
      if (out_valid) begin
         tests++;
         if (q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_out_valid data_out=%h at cycle %0d", data_out, cyc);
         end else begin
            e = q.pop_front();
            if (data_out !== e.d || cyc != e.c) begin
               fails++;
               $display("FAIL sample data_out=%h at cycle %0d, expected %h at cycle %0d", data_out, cyc, e.d, e.c);
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s got %h expected %h", name, act, exp);
      end
   endtask

   // strobe edge is the posedge after driving; output lands two edges later
   task automatic send(input logic [9:0] din, input logic [9:0] exp);
      exp_t n;
      @(negedge sysclk);
      data_in = din;
      data_valid = 1'b1;
      n.d = exp;
      n.c = cyc + 3;
      q.push_back(n);
      @(negedge sysclk);
      data_valid = 1'b0;
      repeat (3) @(negedge sysclk);
   endtask

   task automatic do_reset(input bit pulse);
      int n;
      @(negedge sysclk);
      rst_n = 1'b0;
      data_valid = 1'b0;
      repeat (2) @(negedge sysclk);
      check("rst_data_out", 32'(data_out), 32'h200);
      check("rst_out_valid", 32'(out_valid), 32'h0);
      check("rst_busy", 32'(busy), 32'h1);
      check("rst_overrun", 32'(overrun), 32'h0);
      rst_n = 1'b1;
      n = 0;
      while (busy && n < 100) begin
         @(posedge sysclk);
         #1;
         n++;
         if (pulse && n == 4) data_valid = 1'b1;
         if (pulse && n == 6) data_valid = 1'b0;
      end
      check("clear_busy_cycles", 32'(n), 32'd16);
      repeat (4) @(negedge sysclk);
      check("clear_overrun", 32'(overrun), 32'h0);
   endtask

   initial begin
      logic [9:0] fir_exp [6];
      logic [9:0] iir_exp [10];
      fir_exp = '{10'h300, 10'h200, 10'h200, 10'h180, 10'h200, 10'h200};
      iir_exp = '{10'h300, 10'h200, 10'h200, 10'h180, 10'h200,
                  10'h200, 10'h240, 10'h200, 10'h200, 10'h1E0};
      do_reset(1'b1);
      mode = 2'b00;
      send(10'h1C1, 10'h240);
      send(10'h181, 10'h200);
      mode = 2'b11;
      send(10'h1C1, 10'h240);
      check("pass_overrun", 32'(overrun), 32'h0);
      do_reset(1'b0);
      mode = 2'b01;
      delay_sel = 4'd3;
      for (int i = 0; i < 6; i++) send(i == 0 ? 10'h281 : 10'h181, fir_exp[i]);
      do_reset(1'b0);
      mode = 2'b10;
      for (int i = 0; i < 10; i++) send(i == 0 ? 10'h281 : 10'h181, iir_exp[i]);
      do_reset(1'b0);
      mode = 2'b01;
      delay_sel = 4'd1;
      send(10'h380, 10'h3FF);
`ifdef ECHO_SAT_EN
      send(10'h000, 10'h000);
`else
      send(10'h000, 10'h380);
`endif
      mode = 2'b00;
      @(negedge sysclk);
      data_in = 10'h1C1;
      data_valid = 1'b1;
      e.d = 10'h240;
      e.c = cyc + 3;
      q.push_back(e);
      @(negedge sysclk);
      data_valid = 1'b0;
      @(negedge sysclk);
      data_valid = 1'b1;
      @(negedge sysclk);
      data_valid = 1'b0;
      repeat (3) @(negedge sysclk);
      check("overrun_set", 32'(overrun), 32'h1);
      repeat (10) @(negedge sysclk);
      check("overrun_sticky", 32'(overrun), 32'h1);
      do_reset(1'b0);
      repeat (5) @(negedge sysclk);
      check("queue_drained", 32'(q.size()), 32'h0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
